// File: rtl/mic_event_filter.sv
// mic_event_filter: conditions the raw sound-module output for the wake-up logic.
// Synchronizes mic_raw, rejects short glitches, holds off after each sound,
// emits one-cycle sound pulses and flags a second sound inside the clap window.

module mic_event_filter #(
    parameter int MIN_PULSE   = 50000,
    parameter int HOLDOFF     = 12500000,
    parameter int CLAP_WINDOW = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mic_raw,
    input  logic       enable,
    output logic       mic_clean,
    output logic       sound_pulse,
    output logic       double_clap,
    output logic       busy,
    output logic [7:0] sound_count
);

    localparam int CNT_MAX = (MIN_PULSE > HOLDOFF) ? MIN_PULSE : HOLDOFF;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam int WW      = $clog2(CLAP_WINDOW) + 1;

    // cnt holds the number of high cycles already seen before the current one,
    // so the last qualifying cycle is reached at MIN_PULSE-1.
    localparam logic [CW-1:0] QUAL_LAST = CW'(MIN_PULSE - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF - 1);
    localparam logic [WW-1:0] WIN_LAST  = WW'(CLAP_WINDOW - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_QUALIFY,
        ST_ACTIVE,
        ST_HOLDOFF
    } state_t;

    logic          mic_meta;
    logic          mic_s;
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          pulse_nxt;
    logic          armed;
    logic          armed_nxt;
    logic [WW-1:0] wcnt;
    logic [WW-1:0] wcnt_nxt;
    logic          clap_nxt;

    // Two-flop synchronizer; keeps running regardless of enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            mic_meta <= 1'b0;
            mic_s    <= 1'b0;
        end else begin
            mic_meta <= mic_raw;
            mic_s    <= mic_meta;
        end
    end

    // Sound FSM next state: qualify a sustained high, track it, then hold off.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pulse_nxt = 1'b0;
        if (!enable) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mic_s) begin
                        if (MIN_PULSE == 1) begin
                            state_nxt = ST_ACTIVE;
                            pulse_nxt = 1'b1;
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = ST_QUALIFY;
                            cnt_nxt   = CW'(1);
                        end
                    end
                end
                ST_QUALIFY: begin
                    if (!mic_s) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == QUAL_LAST) begin
                        state_nxt = ST_ACTIVE;
                        pulse_nxt = 1'b1;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                ST_ACTIVE: begin
                    if (!mic_s) begin
                        state_nxt = ST_HOLDOFF;
                        cnt_nxt   = '0;
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt == HOLD_LAST) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Clap tracker next state: a sound arms the window, a second one inside it fires.
    always_comb begin
        armed_nxt = armed;
        wcnt_nxt  = wcnt;
        clap_nxt  = 1'b0;
        if (!enable) begin
            armed_nxt = 1'b0;
            wcnt_nxt  = '0;
        end else if (pulse_nxt) begin
            wcnt_nxt = '0;
            if (armed) begin
                clap_nxt  = 1'b1;
                armed_nxt = 1'b0;
            end else begin
                armed_nxt = 1'b1;
            end
        end else if (armed) begin
            if (wcnt == WIN_LAST) begin
                armed_nxt = 1'b0;
                wcnt_nxt  = '0;
            end else begin
                wcnt_nxt = wcnt + WW'(1);
            end
        end
    end

    // State, counters and all outputs registered together from the next-state values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            armed       <= 1'b0;
            wcnt        <= '0;
            mic_clean   <= 1'b0;
            sound_pulse <= 1'b0;
            double_clap <= 1'b0;
            busy        <= 1'b0;
            sound_count <= 8'd0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            armed       <= armed_nxt;
            wcnt        <= wcnt_nxt;
            mic_clean   <= (state_nxt == ST_ACTIVE);
            sound_pulse <= pulse_nxt;
            double_clap <= clap_nxt;
            busy        <= (state_nxt != ST_IDLE);
            sound_count <= sound_count + 8'(pulse_nxt);
        end
    end

endmodule

// File: tb/tb_mic_event_filter.sv
// tb_mic_event_filter: directed bench for mic_event_filter with a timestamp-based
// reference model compared against the DUT outputs every cycle.

module tb_mic_event_filter;

    localparam int MIN_PULSE   = 4;
    localparam int HOLDOFF     = 10;
    localparam int CLAP_WINDOW = 40;

    logic       clk;
    logic       rst;
    logic       mic_raw;
    logic       enable;
    logic       mic_clean;
    logic       sound_pulse;
    logic       double_clap;
    logic       busy;
    logic [7:0] sound_count;

    int vectors     = 0;
    int miscompares = 0;
    bit check_en    = 0;

    // reference model state, expressed as cycle timestamps
    int cyc          = 0;
    bit s1           = 0;
    bit s2           = 0;
    bit m_in_sound   = 0;
    int m_qual_since = -1;
    int m_block_til  = 0;
    int m_arm        = -1;
    bit e_pulse      = 0;
    bit e_clap       = 0;
    bit e_clean      = 0;
    bit e_busy       = 0;
    int e_count      = 0;

    // observation helpers fed by the compare process
    int last_pulse_cyc = -1;
    int clap_seen      = 0;
    int busy_cycles    = 0;
    int clean_cycles   = 0;

    mic_event_filter #(
        .MIN_PULSE  (MIN_PULSE),
        .HOLDOFF    (HOLDOFF),
        .CLAP_WINDOW(CLAP_WINDOW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mic_raw    (mic_raw),
        .enable     (enable),
        .mic_clean  (mic_clean),
        .sound_pulse(sound_pulse),
        .double_clap(double_clap),
        .busy       (busy),
        .sound_count(sound_count)
    );

    // free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // reference model: decides the outputs of the next cycle from the inputs seen at this edge
    initial begin
        forever begin
            bit ms;
            int n;
            @(posedge clk);
            n   = cyc;
            cyc = n + 1;
            ms  = s2;
            s2  = s1;
            s1  = mic_raw;
            e_pulse = 0;
            e_clap  = 0;
            if (rst) begin
                s1 = 0; s2 = 0;
                m_in_sound = 0; m_qual_since = -1; m_block_til = 0; m_arm = -1;
                e_count = 0;
            end else if (!enable) begin
                m_in_sound = 0; m_qual_since = -1; m_block_til = 0; m_arm = -1;
            end else if (m_in_sound) begin
                if (!ms) begin
                    m_in_sound  = 0;
                    m_block_til = n + 1 + HOLDOFF;
                end
            end else if (n < m_block_til) begin
                m_qual_since = -1;
            end else if (ms) begin
                if (m_qual_since < 0) m_qual_since = n;
                if (n - m_qual_since + 1 >= MIN_PULSE) begin
                    e_pulse      = 1;
                    m_in_sound   = 1;
                    m_qual_since = -1;
                    e_count      = (e_count + 1) % 256;
                    if (m_arm >= 0 && (n + 1) - m_arm <= CLAP_WINDOW) begin
                        e_clap = 1;
                        m_arm  = -1;
                    end else begin
                        m_arm = n + 1;
                    end
                end
            end else begin
                m_qual_since = -1;
            end
            e_clean = m_in_sound;
            e_busy  = m_in_sound || (m_qual_since >= 0) || (n + 1 < m_block_til);
        end
    end

    // compare process: every cycle, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                check_output("sound_pulse", int'(sound_pulse), int'(e_pulse));
                check_output("double_clap", int'(double_clap), int'(e_clap));
                check_output("mic_clean",   int'(mic_clean),   int'(e_clean));
                check_output("busy",        int'(busy),        int'(e_busy));
                check_output("sound_count", int'(sound_count), e_count);
                if (sound_pulse) last_pulse_cyc = cyc;
                if (double_clap) clap_seen++;
                if (busy) busy_cycles++;
                if (mic_clean) clean_cycles++;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_stimulus(input int len);
        mic_raw = 1'b1;
        repeat (len) @(negedge clk);
        mic_raw = 1'b0;
    endtask

    initial begin
        int t0;
        int claps0;
        rst      = 1'b1;
        enable   = 1'b1;
        mic_raw  = 1'b0;
        check_en = 1;
        idle(3);
        check_output("reset_count", int'(sound_count), 0);
        check_output("reset_busy",  int'(busy), 0);
        rst = 1'b0;
        idle(5);

        // glitch shorter than MIN_PULSE
        busy_cycles = 0;
        apply_stimulus(3);
        idle(20);
        check_output("glitch_count", int'(sound_count), 0);
        check_output("glitch_busy_cycles", busy_cycles, 3);

        // valid sound, latency = 2 sync stages + MIN_PULSE
        last_pulse_cyc = -1;
        clean_cycles   = 0;
        t0 = cyc;
        apply_stimulus(12);
        idle(3);
        apply_stimulus(8);
        idle(30);
        check_output("valid_latency", last_pulse_cyc - t0, 6);
        check_output("valid_clean_cycles", clean_cycles, 9);
        check_output("holdoff_count", int'(sound_count), 1);
        apply_stimulus(8);
        idle(30);
        check_output("after_holdoff_count", int'(sound_count), 2);

        // double clap: pulses 25 apart, third one 25 later starts a fresh window
        idle(60);
        claps0 = clap_seen;
        apply_stimulus(6);
        idle(19);
        apply_stimulus(6);
        idle(19);
        apply_stimulus(6);
        idle(50);
        check_output("double_clap_count", clap_seen - claps0, 1);
        check_output("double_clap_sounds", int'(sound_count), 5);

        // window expiry: 45 apart misses, 20 later fires
        idle(60);
        claps0 = clap_seen;
        apply_stimulus(6);
        idle(39);
        apply_stimulus(6);
        idle(14);
        apply_stimulus(6);
        idle(50);
        check_output("expiry_clap_count", clap_seen - claps0, 1);

        // reset during ACTIVE
        idle(60);
        mic_raw = 1'b1;
        idle(8);
        rst = 1'b1;
        idle(1);
        check_output("rst_active_clean", int'(mic_clean), 0);
        check_output("rst_active_busy",  int'(busy), 0);
        check_output("rst_active_count", int'(sound_count), 0);
        rst     = 1'b0;
        mic_raw = 1'b0;
        idle(20);

        // enable dropped during QUALIFY, then re-enabled with mic held high
        apply_stimulus(6);
        idle(30);
        check_output("pre_enable_count", int'(sound_count), 1);
        mic_raw = 1'b1;
        idle(4);
        enable = 1'b0;
        idle(1);
        check_output("disable_busy",  int'(busy), 0);
        check_output("disable_count", int'(sound_count), 1);
        idle(5);
        last_pulse_cyc = -1;
        t0 = cyc;
        enable = 1'b1;
        idle(10);
        check_output("reenable_latency", last_pulse_cyc - t0, 4);
        mic_raw = 1'b0;
        idle(30);
        check_output("reenable_count", int'(sound_count), 2);

        check_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
